// File: rtl/mic_pkg.sv
// Shared types and sizing for the microphone frame writer and its ping-pong buffer.
// No logic here; the buffer and the writer must agree on these values.
// Frame depth must equal the buffer depth.
package mic_pkg;

    typedef enum logic {
        FILL = 1'b0,
        WAIT = 1'b1
    } writer_state_t;

    localparam int FRAME_DEPTH = 512;
    localparam int SAMPLE_W    = 8;
    localparam int FRAME_AW    = 9;

endpackage

// File: rtl/mic_frame_writer_sat_counter.sv
// Saturating up-counter: counts i_inc pulses and sticks at all-ones.
// Latency: count updates on the clock edge after i_inc.
// Backpressure: none; increments past saturation are silently absorbed.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/mic_frame_writer.sv
// Packs a free-running sample stream into DEPTH-word frames on the buffer write port.
// Latency: one cycle from sample_valid to wren; all write-port outputs registered.
// Backpressure: none upstream; samples arriving while waiting for goodToGo are dropped and counted.
module mic_frame_writer
    import mic_pkg::*;
#(
    parameter int DEPTH = FRAME_DEPTH,
    parameter int AW    = FRAME_AW,
    parameter int DW    = SAMPLE_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sample_valid,
    input  logic [DW-1:0] sample,
    input  logic          goodToGo,
    output logic [AW-1:0] w_addr,
    output logic [DW-1:0] w_data,
    output logic          wren,
    output logic          writeDone,
    output logic          accepting,
    output logic [15:0]   frame_count,
    output logic [7:0]    drop_count
);

    writer_state_t r_state;
    writer_state_t w_next_state;

    logic [AW-1:0] r_idx;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;
    logic          r_wren;
    logic          r_done;
    logic          r_accepting;
    logic [15:0]   r_frames;

    logic w_last;
    logic w_accept;
    logic w_drop;
    logic w_resume;

    assign w_last   = (r_idx == AW'(DEPTH - 1));
    assign w_accept = (r_state == FILL) && sample_valid;
    assign w_drop   = (r_state == WAIT) && sample_valid;
    assign w_resume = (r_state == WAIT) && goodToGo;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            FILL:    if (w_accept && w_last) w_next_state = WAIT;
            WAIT:    if (goodToGo)           w_next_state = FILL;
            default: w_next_state = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FILL;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Status flags are registered from the next state so they change in the
    // same cycle as the final write, and read 0 while reset is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_wren      <= 1'b0;
            r_done      <= 1'b0;
            r_accepting <= 1'b0;
            r_frames    <= '0;
        end else begin
            r_wren      <= w_accept;
            r_done      <= (w_next_state == WAIT);
            r_accepting <= (w_next_state == FILL);
            if (w_accept) begin
                r_addr <= r_idx;
                r_data <= sample;
                r_idx  <= w_last ? '0 : r_idx + 1'b1;
            end
            if (w_resume) begin
                r_frames <= r_frames + 1'b1;
            end
        end
    end

    sat_counter #(
        .W(8)
    ) u_drop_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_drop),
        .o_count (drop_count)
    );

    assign w_addr      = r_addr;
    assign w_data      = r_data;
    assign wren        = r_wren;
    assign writeDone   = r_done;
    assign accepting   = r_accepting;
    assign frame_count = r_frames;

endmodule

// File: tb/tb_mic_frame_writer.sv
// Randomized scoreboard bench for mic_frame_writer against a frame-level reference model.
module tb_mic_frame_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_valid;
    logic [7:0]  sample;
    logic        goodToGo;
    logic [8:0]  w_addr;
    logic [7:0]  w_data;
    logic        wren;
    logic        writeDone;
    logic        accepting;
    logic [15:0] frame_count;
    logic [7:0]  drop_count;

    always #5 clk = ~clk;

    mic_frame_writer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample       (sample),
        .goodToGo     (goodToGo),
        .w_addr       (w_addr),
        .w_data       (w_data),
        .wren         (wren),
        .writeDone    (writeDone),
        .accepting    (accepting),
        .frame_count  (frame_count),
        .drop_count   (drop_count)
    );

    typedef struct {
        int addr;
        int data;
        bit done;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: frame position, frames completed, drops seen.
    bit mdl_fill;
    int mdl_idx;
    int mdl_frames;
    int mdl_drops;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mdl_fill   = 1'b1;
        mdl_idx    = 0;
        mdl_frames = 0;
        mdl_drops  = 0;
        exp_q.delete();
    endtask

    task automatic step(input bit v, input bit g, input logic [7:0] d);
        sample_valid = v;
        goodToGo     = g;
        sample       = d;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        goodToGo     = 1'b0;
        if (mdl_fill) begin
            if (v) begin
                exp_q.push_back('{addr: mdl_idx, data: int'(d), done: (mdl_idx == 511)});
                mdl_idx++;
                if (mdl_idx == 512) begin
                    mdl_idx  = 0;
                    mdl_fill = 1'b0;
                end
            end
        end else begin
            if (v && mdl_drops < 255) mdl_drops++;
            if (g) begin
                mdl_fill   = 1'b1;
                mdl_frames = (mdl_frames + 1) % 65536;
            end
        end
    endtask

    task automatic fill_rest();
        int guard = 0;
        while (mdl_fill && guard < 8000) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, 8'($urandom));
            guard++;
        end
        chk("fill_rest_reached_wait", mdl_fill, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_w_addr"}, w_addr, 0);
        chk({tag, "_w_data"}, w_data, 0);
        chk({tag, "_wren"}, wren, 0);
        chk({tag, "_writeDone"}, writeDone, 0);
        chk({tag, "_accepting"}, accepting, 0);
        chk({tag, "_frame_count"}, frame_count, 0);
        chk({tag, "_drop_count"}, drop_count, 0);
    endtask

    // Monitor: pops the expected write whenever the DUT presents one.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("writeDone_track", writeDone, !mdl_fill);
            if (wren === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr %0d data %0d with no expected write", w_addr, w_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wr_addr", w_addr, mon_e.addr);
                    chk("wr_data", w_data, mon_e.data);
                    chk("wr_done", writeDone, mon_e.done);
                end
            end
        end
    end

    initial begin
        logic [7:0] d;
        rst_n        = 1'b0;
        sample_valid = 1'b0;
        goodToGo     = 1'b0;
        sample       = '0;
        model_reset();
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b1, 8'h00);
        chk("accepting_after_reset", accepting, 1);
        chk("frame_count_gtg_in_fill", frame_count, 0);

        // Single frame, back to back.
        for (int i = 0; i < 512; i++) step(1'b1, 1'b0, 8'(i));
        chk("frame1_writeDone", writeDone, 1);
        chk("frame1_accepting", accepting, 0);
        chk("frame1_w_addr", w_addr, 511);
        chk("frame1_drop", drop_count, 0);
        chk("frame1_frames", frame_count, 0);

        // Wait with five drops, then resume.
        for (int c = 0; c < 20; c++) step((c % 4) == 0, 1'b0, 8'($urandom));
        chk("wait_writeDone_held", writeDone, 1);
        chk("wait_drop5", drop_count, mdl_drops);
        chk("wait_drop5_const", drop_count, 5);
        chk("wait_addr_held", w_addr, 511);
        step(1'b0, 1'b1, 8'h00);
        chk("resume_writeDone", writeDone, 0);
        chk("resume_accepting", accepting, 1);
        chk("resume_frames", frame_count, 1);
        chk("resume_wren_idle", wren, 0);
        d = 8'($urandom);
        step(1'b1, 1'b0, d);
        chk("resume_first_addr", w_addr, 0);
        chk("resume_first_data", w_data, d);
        fill_rest();

        // goodToGo coincident with a sample: sample is dropped.
        step(1'b1, 1'b1, 8'hAA);
        chk("coinc_drop", drop_count, 6);
        chk("coinc_frames", frame_count, 2);
        chk("coinc_no_write", wren, 0);
        d = 8'($urandom);
        step(1'b1, 1'b0, d);
        chk("coinc_next_addr", w_addr, 0);
        chk("coinc_next_data", w_data, d);
        fill_rest();

        // Saturation of the drop counter.
        for (int c = 0; c < 300; c++) step(1'b1, 1'b0, 8'($urandom));
        chk("sat_drop", drop_count, 255);
        chk("sat_model", drop_count, mdl_drops);
        step(1'b1, 1'b1, 8'h00);
        chk("sat_frames", frame_count, 3);
        chk("sat_still_255", drop_count, 255);

        // Gapped input with stray goodToGo pulses in FILL.
        for (int c = 0; c < 1000; c++) step((c % 2) == 0, $urandom_range(0, 3) == 0, 8'($urandom));
        chk("gap_writeDone", writeDone, 0);
        chk("gap_last_addr", w_addr, 499);
        chk("gap_frames", frame_count, 3);

        // Reset mid-frame.
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst1");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 8'($urandom));
        chk("pre_rst_addr", w_addr, 99);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst2");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 8'h00);
        d = 8'($urandom_range(1, 255));
        step(1'b1, 1'b0, d);
        chk("post_rst_addr", w_addr, 0);
        chk("post_rst_data", w_data, d);
        chk("post_rst_wren", wren, 1);
        chk("post_rst_frames", frame_count, 0);
        step(1'b0, 1'b0, 8'h00);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
